// File: rtl/rx_cpu_buf_if.sv
// Purpose : CPU/RX-FIFO side bundle of the two-byte receive holding buffer.
// Latency : n/a (signal grouping only).
// Backpr. : n/a; the buffer throttles the FIFO through fifo_rd.
// Ports   : slave  = rx_cpu_buf (reads CPU/FIFO controls, drives status/data)
//           master = CPU + RX FIFO side (drives controls, reads status/data)
interface rx_cpu_buf_if;
    logic        rd_byte;     // consume oldest byte
    logic        rd_word;     // consume both bytes
    logic        flush;       // drop held and in-flight bytes
    logic        clr_err;     // clear sticky underflow
    logic        fifo_empty;  // RX FIFO has no data
    logic [7:0]  fifo_q;      // RX FIFO data, valid the cycle after fifo_rd
    logic        fifo_rd;     // pop request to RX FIFO
    logic [15:0] q;           // {oldest, next}
    logic [1:0]  count;       // bytes held: 0..2
    logic        empty;
    logic        full;
    logic        underflow;   // sticky illegal-read flag

    modport slave (
        input  rd_byte, rd_word, flush, clr_err, fifo_empty, fifo_q,
        output fifo_rd, q, count, empty, full, underflow
    );

    modport master (
        output rd_byte, rd_word, flush, clr_err, fifo_empty, fifo_q,
        input  fifo_rd, q, count, empty, full, underflow
    );
endinterface

// File: rtl/rx_cpu_buf.sv
// Purpose : two-byte CPU read buffer in front of an RX FIFO (byte/word reads).
// Latency : reads take effect right after the edge; FIFO bytes show 2 edges after fifo_rd.
// Backpr. : pops only while held + in-flight bytes < 2; reads never credit room early.
// Ports   : clk, reset (async, active-high); bus = rx_cpu_buf_if.slave carrying
//           CPU controls (rd_byte/rd_word/flush/clr_err), FIFO side (fifo_empty,
//           fifo_q, fifo_rd) and status/data (q, count, empty, full, underflow).
module rx_cpu_buf (
    input  logic        clk,
    input  logic        reset,
    rx_cpu_buf_if.slave bus
);
    logic [7:0] r_u;          // oldest byte (index 0)
    logic [7:0] r_l;          // next byte (index 1)
    logic [1:0] r_count;
    logic       r_pending;    // a FIFO byte lands on fifo_q this cycle
    logic       r_underflow;

    logic       w_rd_byte;
    logic       w_rd_word;
    logic       w_legal_byte;
    logic       w_legal_word;
    logic       w_illegal;
    logic [1:0] w_count_rd;   // count after any legal read this cycle
    logic [2:0] w_occupancy;  // held + in-flight, one bit wider so 2+1 cannot wrap
    logic       w_fifo_rd;

    // rd_byte has priority; a simultaneous rd_word is dropped.
    assign w_rd_byte    = bus.rd_byte;
    assign w_rd_word    = bus.rd_word & ~bus.rd_byte;
    assign w_legal_byte = w_rd_byte & (r_count != 2'd0);
    assign w_legal_word = w_rd_word & (r_count == 2'd2);
    assign w_illegal    = (w_rd_byte & (r_count == 2'd0)) |
                          (w_rd_word & (r_count != 2'd2));

    always_comb begin
        w_count_rd = r_count;
        if (w_legal_byte) begin
            w_count_rd = r_count - 2'd1;
        end else if (w_legal_word) begin
            w_count_rd = 2'd0;
        end
    end

    // Room is judged on the registered state only, so a read in the same
    // cycle does not open a slot until the next cycle.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_pending};
    assign w_fifo_rd   = ~reset & ~bus.flush & ~bus.fifo_empty & (w_occupancy < 3'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_u         <= 8'h00;
            r_l         <= 8'h00;
            r_count     <= 2'd0;
            r_pending   <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pending <= w_fifo_rd;

            // Set beats clear; flush masks reads entirely.
            if (w_illegal && !bus.flush) begin
                r_underflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_underflow <= 1'b0;
            end

            if (bus.flush) begin
                r_count <= 2'd0;
            end else begin
                if (w_legal_byte) begin
                    r_u <= r_l;
                end
                // Arrival slot follows the post-read count; a later write to
                // r_u here overrides the shift above when the buffer drained.
                if (r_pending) begin
                    if (w_count_rd == 2'd0) begin
                        r_u <= bus.fifo_q;
                    end else begin
                        r_l <= bus.fifo_q;
                    end
                end
                r_count <= w_count_rd + {1'b0, r_pending};
            end
        end
    end

    assign bus.fifo_rd   = w_fifo_rd;
    assign bus.q         = {r_u, r_l};
    assign bus.count     = r_count;
    assign bus.empty     = (r_count == 2'd0);
    assign bus.full      = (r_count == 2'd2);
    assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_rx_cpu_buf.sv
// Purpose : directed self-checking bench for rx_cpu_buf with a small RX FIFO model.
// Latency : model FIFO returns data the cycle after fifo_rd, like the real FIFO.
// Backpr. : model pops only when the buffer raises fifo_rd.
module tb_rx_cpu_buf;
    logic clk;
    logic reset;

    rx_cpu_buf_if bus ();

    rx_cpu_buf dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RX FIFO model: pointer pair over a byte array.
    logic [7:0] fmem [0:63];
    int         rp = 0;
    int         wp = 0;
    logic [7:0] fq = 8'h00;

    assign bus.fifo_empty = (rp == wp);
    assign bus.fifo_q     = fq;

    always @(posedge clk) begin
        if (bus.fifo_rd) begin
            fq <= fmem[rp[5:0]];
            rp <= rp + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fifo_push(input logic [7:0] b);
        fmem[wp[5:0]] = b;
        wp = wp + 1;
    endtask

    task automatic wait_count(input string tag, input logic [1:0] target, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (bus.count == target) break;
            tick();
        end
        check(tag, 16'(bus.count), 16'(target));
    endtask

    logic [7:0] got_b [0:7];
    int         n_got;

    initial begin
        reset       = 1'b1;
        bus.rd_byte = 1'b0;
        bus.rd_word = 1'b0;
        bus.flush   = 1'b0;
        bus.clr_err = 1'b0;
        #2;
        check("rst_count",  16'(bus.count), 16'd0);
        check("rst_q",      bus.q, 16'h0000);
        check("rst_empty",  16'(bus.empty), 16'd1);
        check("rst_full",   16'(bus.full), 16'd0);
        check("rst_fifo_rd",16'(bus.fifo_rd), 16'd0);
        check("rst_uflow",  16'(bus.underflow), 16'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Fill: three bytes, no reads; only two are taken.
        fifo_push(8'hA1); fifo_push(8'hB2); fifo_push(8'hC3);
        #1;
        check("fill_rd0", 16'(bus.fifo_rd), 16'd1);
        tick();
        check("fill_rd1", 16'(bus.fifo_rd), 16'd1);
        tick();
        check("fill_rd2", 16'(bus.fifo_rd), 16'd0);
        check("fill_u1",  16'(bus.q[15:8]), 16'h00A1);
        check("fill_c1",  16'(bus.count), 16'd1);
        tick();
        check("fill_q",     bus.q, 16'hA1B2);
        check("fill_count", 16'(bus.count), 16'd2);
        check("fill_full",  16'(bus.full), 16'd1);
        check("fill_rd",    16'(bus.fifo_rd), 16'd0);
        check("fill_left",  16'(bus.fifo_empty), 16'd0);

        // Legal word read empties; the leftover 0xC3 then streams in.
        bus.rd_word = 1'b1; tick(); bus.rd_word = 1'b0;
        check("word_count", 16'(bus.count), 16'd0);
        check("word_empty", 16'(bus.empty), 16'd1);
        tick(); tick();
        check("c3_u",     16'(bus.q[15:8]), 16'h00C3);
        check("c3_count", 16'(bus.count), 16'd1);
        bus.rd_byte = 1'b1; tick(); bus.rd_byte = 1'b0;
        check("drain_empty", 16'(bus.empty), 16'd1);

        // Streaming bytes: read whenever something is held.
        for (int i = 0; i < 8; i++) fifo_push(8'(i + 1));
        n_got = 0;
        for (int cyc = 0; cyc < 60 && n_got < 8; cyc++) begin
            if (bus.count != 2'd0) begin
                got_b[n_got] = bus.q[15:8];
                n_got++;
                bus.rd_byte = 1'b1;
            end else begin
                bus.rd_byte = 1'b0;
            end
            tick();
        end
        bus.rd_byte = 1'b0;
        check("stream_n", 16'(n_got), 16'd8);
        for (int i = 0; i < 8; i++) check($sformatf("stream_b%0d", i), 16'(got_b[i]), 16'(i + 1));
        check("stream_uflow", 16'(bus.underflow), 16'd0);
        check("stream_count", 16'(bus.count), 16'd0);

        // Word read with a byte waiting behind it.
        fifo_push(8'h11); fifo_push(8'h22);
        wait_count("w_fill", 2'd2, 10);
        check("w_q", bus.q, 16'h1122);
        fifo_push(8'h33);
        #1;
        check("w_blocked", 16'(bus.fifo_rd), 16'd0);
        bus.rd_word = 1'b1; tick(); bus.rd_word = 1'b0;
        check("w_count0", 16'(bus.count), 16'd0);
        tick(); tick();
        check("w_u33",   16'(bus.q[15:8]), 16'h0033);
        check("w_count1",16'(bus.count), 16'd1);
        bus.rd_word = 1'b1; tick(); bus.rd_word = 1'b0;
        check("w_uflow",   16'(bus.underflow), 16'd1);
        check("w_keep_c",  16'(bus.count), 16'd1);
        check("w_keep_u",  16'(bus.q[15:8]), 16'h0033);

        // Priority of rd_byte over rd_word, then clear vs set.
        bus.rd_byte = 1'b1; tick(); bus.rd_byte = 1'b0;
        fifo_push(8'h55); fifo_push(8'h66);
        wait_count("p_fill", 2'd2, 10);
        check("p_q", bus.q, 16'h5566);
        bus.rd_byte = 1'b1; bus.rd_word = 1'b1; tick();
        bus.rd_byte = 1'b0; bus.rd_word = 1'b0;
        check("p_u66",   16'(bus.q[15:8]), 16'h0066);
        check("p_count", 16'(bus.count), 16'd1);
        bus.rd_byte = 1'b1; tick();
        bus.clr_err = 1'b1; tick();
        bus.rd_byte = 1'b0; bus.clr_err = 1'b0;
        check("p_set_wins", 16'(bus.underflow), 16'd1);
        check("p_ill_cnt",  16'(bus.count), 16'd0);
        bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
        check("p_cleared",  16'(bus.underflow), 16'd0);

        // Illegal rd_byte at count 0 while a byte lands.
        fifo_push(8'h99);
        tick();
        bus.rd_byte = 1'b1; tick(); bus.rd_byte = 1'b0;
        check("ia_u",     16'(bus.q[15:8]), 16'h0099);
        check("ia_count", 16'(bus.count), 16'd1);
        check("ia_uflow", 16'(bus.underflow), 16'd1);
        bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;

        // Flush with 0x77 in flight, 0x88 still in the FIFO.
        fifo_push(8'h77); fifo_push(8'h88);
        tick();
        bus.flush = 1'b1;
        #1;
        check("fl_rd0", 16'(bus.fifo_rd), 16'd0);
        tick();
        check("fl_count", 16'(bus.count), 16'd0);
        check("fl_empty", 16'(bus.empty), 16'd1);
        bus.rd_byte = 1'b1;
        #1;
        check("fl_rd1", 16'(bus.fifo_rd), 16'd0);
        tick();
        bus.flush = 1'b0; bus.rd_byte = 1'b0;
        check("fl_uflow", 16'(bus.underflow), 16'd0);
        check("fl_count2",16'(bus.count), 16'd0);
        tick(); tick();
        check("fl_u88",   16'(bus.q[15:8]), 16'h0088);
        check("fl_c1",    16'(bus.count), 16'd1);
        bus.rd_byte = 1'b1; tick(); bus.rd_byte = 1'b0;

        // Asynchronous reset between edges with a full buffer.
        fifo_push(8'hAA); fifo_push(8'hBB);
        wait_count("ar_fill", 2'd2, 10);
        check("ar_q", bus.q, 16'hAABB);
        fifo_push(8'hCC);
        #2;
        reset = 1'b1;
        #1;
        check("ar_count", 16'(bus.count), 16'd0);
        check("ar_q0",    bus.q, 16'h0000);
        check("ar_rd",    16'(bus.fifo_rd), 16'd0);
        check("ar_empty", 16'(bus.empty), 16'd1);
        check("ar_full",  16'(bus.full), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ar_rd_after", 16'(bus.fifo_rd), 16'd1);
        @(negedge clk);
        tick();
        check("ar_qcc",  bus.q, 16'hCC00);
        check("ar_c1",   16'(bus.count), 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
